io_amo_master: RTL and testbench

- Wishbone master directly upstream of the IO bus. Converts one RV32A request from the CPU memory stage (LR.W, SC.W, AMO*.W) into tagged IO bus cycles.
- LR.W becomes one LRSC-tagged read. SC.W becomes one LRSC-tagged write.
- AMO*.W becomes an AMO-tagged read (lock), a one-cycle ALU step, then an AMO-tagged write (unlock).
- The block returns the rd value to the CPU.

---
 rtl/io_amo_master_if.sv | 42 ++++
 rtl/io_amo_master.sv | 223 ++++++++++++++++++++++
 tb/tb_io_amo_master.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/io_amo_master_if.sv
`default_nettype none
// ============================================================================
// Module      : io_amo_master_if
// Description : Wishbone bus bundle between io_amo_master and the IO bus.
//               The master modport drives stb/cyc/we/addr/tag/data/sel and
//               receives ack/err/read data/data tag. The slave modport is
//               the mirror image.
//   stb_o, cyc_o, we_o : Wishbone cycle controls
//   addr_o             : byte address
//   addr_tag_o         : transaction tag (NONE / LRSC / AMO)
//   data_o, sel_o      : write data, byte select
//   ack_i, err_i       : slave responses
//   data_i             : read data
//   data_tag_i         : set when the IO bus suppressed an SC write
// Revision    : 1.0 - initial release
// ============================================================================
interface io_amo_master_if #(
    parameter int ADDR_TAG_BITS = 2
) ();
    logic                     stb_o;
    logic                     cyc_o;
    logic                     we_o;
    logic [31:0]              addr_o;
    logic [ADDR_TAG_BITS-1:0] addr_tag_o;
    logic [31:0]              data_o;
    logic [3:0]               sel_o;
    logic                     ack_i;
    logic                     err_i;
    logic [31:0]              data_i;
    logic                     data_tag_i;

    modport master (
        output stb_o, cyc_o, we_o, addr_o, addr_tag_o, data_o, sel_o,
        input  ack_i, err_i, data_i, data_tag_i
    );

    modport slave (
        input  stb_o, cyc_o, we_o, addr_o, addr_tag_o, data_o, sel_o,
        output ack_i, err_i, data_i, data_tag_i
    );
endinterface
`default_nettype wire

// File: rtl/io_amo_master.sv
`default_nettype none
// ============================================================================
// Module      : io_amo_master
// Description : Converts one RV32A request (LR.W, SC.W, AMO*.W) into tagged
//               Wishbone cycles on the IO bus and returns the rd value.
//               LR  : one LRSC-tagged read.
//               SC  : one LRSC-tagged write; rd = data_tag_i at the ack.
//               AMO : AMO-tagged read (lock), one ALU cycle, AMO-tagged
//                     write (unlock); rd = old memory value.
//               Optional macro IO_AMO_MINMAX_EN enables AMOMIN/MAX/MINU/MAXU;
//               without it those opcodes are rejected as illegal.
// Ports       : clk_i, rst_i (async, active-low)
//               req_i/req_op_i/req_addr_i/req_data_i : CPU request
//               busy_o, done_o, result_o, req_err_o  : CPU status/result
//               bus                                  : Wishbone master port
// Revision    : 1.0 - initial release
// ============================================================================
module io_amo_master #(
    parameter int                       ACK_TIMEOUT_CYCLES = 255,
    parameter int                       ADDR_TAG_BITS      = 2,
    parameter logic [ADDR_TAG_BITS-1:0] ADDR_TAG_NONE      = 0,
    parameter logic [ADDR_TAG_BITS-1:0] ADDR_TAG_LRSC      = 1,
    parameter logic [ADDR_TAG_BITS-1:0] ADDR_TAG_AMO       = 2
) (
    input  wire logic        clk_i,
    input  wire logic        rst_i,
    input  wire logic        req_i,
    input  wire logic [4:0]  req_op_i,
    input  wire logic [31:0] req_addr_i,
    input  wire logic [31:0] req_data_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [31:0]      result_o,
    output logic             req_err_o,
    io_amo_master_if.master  bus
);
    localparam logic [4:0] c_OP_ADD  = 5'b00000;
    localparam logic [4:0] c_OP_SWAP = 5'b00001;
    localparam logic [4:0] c_OP_LR   = 5'b00010;
    localparam logic [4:0] c_OP_SC   = 5'b00011;
    localparam logic [4:0] c_OP_XOR  = 5'b00100;
    localparam logic [4:0] c_OP_OR   = 5'b01000;
    localparam logic [4:0] c_OP_AND  = 5'b01100;
`ifdef IO_AMO_MINMAX_EN
    localparam logic [4:0] c_OP_MIN  = 5'b10000;
    localparam logic [4:0] c_OP_MAX  = 5'b10100;
    localparam logic [4:0] c_OP_MINU = 5'b11000;
    localparam logic [4:0] c_OP_MAXU = 5'b11100;
`endif
    localparam int c_TMO_W = $clog2(ACK_TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_CALC = 3'd2,
        S_WR   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t                   r_state, w_state_nxt;
    logic                     r_stb, r_cyc, r_we, r_busy, r_done, r_req_err;
    logic [31:0]              r_addr, r_data, r_result;
    logic [4:0]               r_op;
    logic [ADDR_TAG_BITS-1:0] r_tag;
    logic [c_TMO_W-1:0]       r_tmo_cnt;
    logic                     w_op_legal, w_bad, w_set_err, w_timeout, w_accept;
    logic [31:0]              w_calc;

    always_comb begin
        w_op_legal = 1'b0;
        case (req_op_i)
            c_OP_ADD, c_OP_SWAP, c_OP_LR, c_OP_SC,
            c_OP_XOR, c_OP_OR, c_OP_AND:       w_op_legal = 1'b1;
`ifdef IO_AMO_MINMAX_EN
            c_OP_MIN, c_OP_MAX, c_OP_MINU, c_OP_MAXU: w_op_legal = 1'b1;
`endif
            default:                           w_op_legal = 1'b0;
        endcase
    end

    assign w_accept  = (r_state == S_IDLE) && req_i;
    assign w_bad     = (req_addr_i[1:0] != 2'b00) || !w_op_legal;
    assign w_timeout = (r_tmo_cnt == c_TMO_W'(ACK_TIMEOUT_CYCLES - 1));

    // ALU step: r_result holds the old memory value, r_data holds rs2.
    always_comb begin
        w_calc = r_data;
        case (r_op)
            c_OP_ADD:  w_calc = r_result + r_data;
            c_OP_XOR:  w_calc = r_result ^ r_data;
            c_OP_AND:  w_calc = r_result & r_data;
            c_OP_OR:   w_calc = r_result | r_data;
`ifdef IO_AMO_MINMAX_EN
            c_OP_MIN:  w_calc = ($signed(r_result) < $signed(r_data)) ? r_result : r_data;
            c_OP_MAX:  w_calc = ($signed(r_result) > $signed(r_data)) ? r_result : r_data;
            c_OP_MINU: w_calc = (r_result < r_data) ? r_result : r_data;
            c_OP_MAXU: w_calc = (r_result > r_data) ? r_result : r_data;
`endif
            default:   w_calc = r_data;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // err_i is tested before ack_i so a simultaneous pair aborts.
    always_comb begin
        w_state_nxt = r_state;
        w_set_err   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_i) begin
                    if (w_bad) begin
                        w_state_nxt = S_DONE;
                        w_set_err   = 1'b1;
                    end else if (req_op_i == c_OP_SC) begin
                        w_state_nxt = S_WR;
                    end else begin
                        w_state_nxt = S_RD;
                    end
                end
            end
            S_RD: begin
                if (bus.err_i) begin
                    w_state_nxt = S_DONE;
                    w_set_err   = 1'b1;
                end else if (bus.ack_i) begin
                    w_state_nxt = (r_op == c_OP_LR) ? S_DONE : S_CALC;
                end else if (w_timeout) begin
                    w_state_nxt = S_DONE;
                    w_set_err   = 1'b1;
                end
            end
            S_CALC: w_state_nxt = S_WR;
            S_WR: begin
                if (bus.err_i) begin
                    w_state_nxt = S_DONE;
                    w_set_err   = 1'b1;
                end else if (bus.ack_i) begin
                    w_state_nxt = S_DONE;
                end else if (w_timeout) begin
                    w_state_nxt = S_DONE;
                    w_set_err   = 1'b1;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Control outputs are registered from the next state so they are glitch
    // free and drop asynchronously with reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_stb     <= 1'b0;
            r_cyc     <= 1'b0;
            r_we      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_req_err <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
            r_result  <= '0;
            r_op      <= '0;
            r_tag     <= ADDR_TAG_NONE;
            r_tmo_cnt <= '0;
        end else begin
            r_stb  <= (w_state_nxt == S_RD) || (w_state_nxt == S_WR);
            r_cyc  <= (w_state_nxt == S_RD) || (w_state_nxt == S_CALC) ||
                      (w_state_nxt == S_WR);
            r_we   <= (w_state_nxt == S_WR);
            r_busy <= (w_state_nxt != S_IDLE);
            r_done <= (w_state_nxt == S_DONE);

            if (w_accept) begin
                r_addr    <= req_addr_i;
                r_data    <= req_data_i;
                r_op      <= req_op_i;
                r_result  <= '0;
                r_req_err <= w_bad;
                if (w_bad)
                    r_tag <= ADDR_TAG_NONE;
                else if ((req_op_i == c_OP_LR) || (req_op_i == c_OP_SC))
                    r_tag <= ADDR_TAG_LRSC;
                else
                    r_tag <= ADDR_TAG_AMO;
            end else if (w_set_err) begin
                r_req_err <= 1'b1;
            end

            if ((r_state == S_RD) && bus.ack_i && !bus.err_i)
                r_result <= bus.data_i;
            if ((r_state == S_WR) && bus.ack_i && !bus.err_i && (r_op == c_OP_SC))
                r_result <= {31'd0, bus.data_tag_i};
            if (r_state == S_CALC)
                r_data <= w_calc;

            if (!w_accept && (w_state_nxt == S_DONE))
                r_tag <= ADDR_TAG_NONE;

            // Held at zero whenever stb is low, so every stb rise starts at 0.
            if ((r_state != S_RD) && (r_state != S_WR))
                r_tmo_cnt <= '0;
            else if (!bus.ack_i && !bus.err_i)
                r_tmo_cnt <= r_tmo_cnt + c_TMO_W'(1);
        end
    end

    assign busy_o         = r_busy;
    assign done_o         = r_done;
    assign result_o       = r_result;
    assign req_err_o      = r_req_err;
    assign bus.stb_o      = r_stb;
    assign bus.cyc_o      = r_cyc;
    assign bus.we_o       = r_we;
    assign bus.addr_o     = r_addr;
    assign bus.addr_tag_o = r_tag;
    assign bus.data_o     = r_data;
    assign bus.sel_o      = 4'hF;
endmodule
`default_nettype wire

// File: tb/tb_io_amo_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_amo_master
// Description : Directed self-checking bench for io_amo_master with a
//               behavioural Wishbone slave (programmable ack delay, error,
//               silence) and a bus monitor. Timeout is set to 8 cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_amo_master;
    localparam int c_TMO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_i;
    logic [4:0]  req_op_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_data_i;
    logic        busy_o, done_o, req_err_o;
    logic [31:0] result_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    io_amo_master_if #(.ADDR_TAG_BITS(2)) bus();

    io_amo_master #(.ACK_TIMEOUT_CYCLES(c_TMO)) u_dut (
        .clk_i      (clk),
        .rst_i      (rst_n),
        .req_i      (req_i),
        .req_op_i   (req_op_i),
        .req_addr_i (req_addr_i),
        .req_data_i (req_data_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .result_o   (result_o),
        .req_err_o  (req_err_o),
        .bus        (bus)
    );

    // Behavioural slave
    logic        slv_ack_en = 1'b1;
    logic        slv_err_en = 1'b0;
    int          slv_delay  = 0;
    logic [31:0] slv_rdata  = '0;
    logic        slv_tag    = 1'b0;
    int          stb_cnt    = 0;

    assign bus.ack_i      = bus.stb_o && slv_ack_en && (stb_cnt >= slv_delay);
    assign bus.err_i      = bus.stb_o && slv_err_en && !bus.we_o;
    assign bus.data_i     = slv_rdata;
    assign bus.data_tag_i = slv_tag;

    // Bus monitor
    int          mon_stb_cycles = 0;
    int          mon_wr_cnt     = 0;
    logic [31:0] mon_wr_data    = '0;
    logic [1:0]  mon_wr_tag     = '0;
    logic [1:0]  mon_rd_tag     = '0;
    logic [31:0] mon_rd_addr    = '0;

    always @(posedge clk) begin
        stb_cnt <= (bus.stb_o && !bus.ack_i && !bus.err_i) ? stb_cnt + 1 : 0;
        if (bus.stb_o) mon_stb_cycles <= mon_stb_cycles + 1;
        if (bus.stb_o && bus.ack_i && !bus.err_i) begin
            if (bus.we_o) begin
                mon_wr_cnt  <= mon_wr_cnt + 1;
                mon_wr_data <= bus.data_o;
                mon_wr_tag  <= bus.addr_tag_o;
            end else begin
                mon_rd_tag  <= bus.addr_tag_o;
                mon_rd_addr <= bus.addr_o;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Results of the last run_op
    int          t_lat;
    logic [31:0] t_res;
    logic        t_err, t_we1, t_cyc2, t_stb2, t_done_after, t_busy_after;
    int          t_stb_d, t_wr_d;

    // Request in cycle T; t_lat = cycles after T until done_o is seen.
    task automatic run_op(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] data);
        int s_stb, s_wr;
        s_stb = mon_stb_cycles;
        s_wr  = mon_wr_cnt;
        @(negedge clk);
        req_i = 1'b1; req_op_i = op; req_addr_i = addr; req_data_i = data;
        t_lat = -1; t_res = 'x; t_err = 1'bx; t_we1 = 1'bx; t_cyc2 = 1'bx; t_stb2 = 1'bx;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            req_i = 1'b0;
            if (k == 1) t_we1 = bus.we_o;
            if (k == 2) begin t_cyc2 = bus.cyc_o; t_stb2 = bus.stb_o; end
            if (done_o) begin
                t_lat = k; t_res = result_o; t_err = req_err_o;
                break;
            end
        end
        @(negedge clk);
        t_done_after = done_o;
        t_busy_after = busy_o;
        t_stb_d = mon_stb_cycles - s_stb;
        t_wr_d  = mon_wr_cnt - s_wr;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s_wr;
        rst_n = 1'b0; req_i = 1'b0; req_op_i = '0; req_addr_i = '0; req_data_i = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_stb",    32'(bus.stb_o), 0);
        check_eq("rst_cyc",    32'(bus.cyc_o), 0);
        check_eq("rst_we",     32'(bus.we_o), 0);
        check_eq("rst_busy",   32'(busy_o), 0);
        check_eq("rst_done",   32'(done_o), 0);
        check_eq("rst_err",    32'(req_err_o), 0);
        check_eq("rst_result", result_o, 0);
        check_eq("rst_addr",   bus.addr_o, 0);
        check_eq("rst_data",   bus.data_o, 0);
        check_eq("rst_tag",    32'(bus.addr_tag_o), 0);
        check_eq("sel",        32'(bus.sel_o), 32'hF);
        rst_n = 1'b1;
        @(negedge clk);

        // LR, slave acks one cycle after stb
        slv_delay = 1; slv_rdata = 32'hDEAD_BEEF;
        run_op(5'b00010, 32'h10, 32'h0);
        check_eq("lr_lat",     t_lat, 3);
        check_eq("lr_we",      32'(t_we1), 0);
        check_eq("lr_tag",     32'(mon_rd_tag), 1);
        check_eq("lr_addr",    mon_rd_addr, 32'h10);
        check_eq("lr_result",  t_res, 32'hDEAD_BEEF);
        check_eq("lr_err",     32'(t_err), 0);
        check_eq("lr_onepulse",32'(t_done_after), 0);
        check_eq("lr_busy_end",32'(t_busy_after), 0);

        // LR zero-wait minimum latency
        slv_delay = 0; slv_rdata = 32'h1234_5678;
        run_op(5'b00010, 32'h14, 32'h0);
        check_eq("lr0_lat",    t_lat, 2);
        check_eq("lr0_result", t_res, 32'h1234_5678);

        // SC success then failure
        slv_tag = 1'b0;
        run_op(5'b00011, 32'h10, 32'h5);
        check_eq("sc0_lat",    t_lat, 2);
        check_eq("sc0_we",     32'(t_we1), 1);
        check_eq("sc0_tag",    32'(mon_wr_tag), 1);
        check_eq("sc0_data",   mon_wr_data, 32'h5);
        check_eq("sc0_result", t_res, 0);
        slv_tag = 1'b1;
        run_op(5'b00011, 32'h10, 32'h5);
        check_eq("sc1_result", t_res, 1);
        check_eq("sc1_err",    32'(t_err), 0);
        slv_tag = 1'b0;

        // AMOADD wraps
        slv_rdata = 32'hFFFF_FFFF;
        run_op(5'b00000, 32'h20, 32'h2);
        check_eq("add_lat",    t_lat, 4);
        check_eq("add_rdtag",  32'(mon_rd_tag), 2);
        check_eq("add_calc_cyc", 32'(t_cyc2), 1);
        check_eq("add_calc_stb", 32'(t_stb2), 0);
        check_eq("add_wdata",  mon_wr_data, 32'h1);
        check_eq("add_wrtag",  32'(mon_wr_tag), 2);
        check_eq("add_result", t_res, 32'hFFFF_FFFF);
        check_eq("add_err",    32'(t_err), 0);

        // AMOXOR / AMOAND / AMOOR / AMOSWAP
        slv_rdata = 32'hF0F0_1234;
        run_op(5'b00100, 32'h24, 32'hFF00_00FF);
        check_eq("xor_wdata", mon_wr_data, 32'h0FF0_12CB);
        run_op(5'b01100, 32'h24, 32'hFF00_00FF);
        check_eq("and_wdata", mon_wr_data, 32'hF000_0034);
        run_op(5'b01000, 32'h24, 32'hFF00_00FF);
        check_eq("or_wdata",  mon_wr_data, 32'hFFF0_12FF);
        run_op(5'b00001, 32'h24, 32'hCAFE_0001);
        check_eq("swap_wdata",  mon_wr_data, 32'hCAFE_0001);
        check_eq("swap_result", t_res, 32'hF0F0_1234);

        // MIN / MINU
        slv_rdata = 32'h8000_0000;
`ifdef IO_AMO_MINMAX_EN
        run_op(5'b10000, 32'h28, 32'h1);
        check_eq("min_wdata",  mon_wr_data, 32'h8000_0000);
        check_eq("min_lat",    t_lat, 4);
        run_op(5'b11000, 32'h28, 32'h1);
        check_eq("minu_wdata", mon_wr_data, 32'h1);
        run_op(5'b10100, 32'h28, 32'h1);
        check_eq("max_wdata",  mon_wr_data, 32'h1);
        run_op(5'b11100, 32'h28, 32'h1);
        check_eq("maxu_wdata", mon_wr_data, 32'h8000_0000);
`else
        run_op(5'b10000, 32'h28, 32'h1);
        check_eq("min_err",    32'(t_err), 1);
        check_eq("min_nostb",  t_stb_d, 0);
        check_eq("min_lat",    t_lat, 1);
        run_op(5'b11000, 32'h28, 32'h1);
        check_eq("minu_err",   32'(t_err), 1);
        check_eq("minu_nostb", t_stb_d, 0);
`endif

        // Misaligned address
        slv_rdata = 32'h7777_7777;
        run_op(5'b00000, 32'h22, 32'h1);
        check_eq("mis_err",    32'(t_err), 1);
        check_eq("mis_nostb",  t_stb_d, 0);
        check_eq("mis_result", t_res, 0);
        check_eq("mis_lat",    t_lat, 1);

        // Illegal opcode
        run_op(5'b00101, 32'h20, 32'h1);
        check_eq("ill_err",   32'(t_err), 1);
        check_eq("ill_nostb", t_stb_d, 0);

        // Silent slave -> timeout
        slv_ack_en = 1'b0;
        run_op(5'b00010, 32'h30, 32'h0);
        check_eq("tmo_stbcyc", t_stb_d, c_TMO);
        check_eq("tmo_lat",    t_lat, c_TMO + 1);
        check_eq("tmo_err",    32'(t_err), 1);
        check_eq("tmo_cyc",    32'(bus.cyc_o), 0);
        slv_ack_en = 1'b1;

        // err_i during RD of an AMO: no write phase
        slv_err_en = 1'b1;
        run_op(5'b00000, 32'h20, 32'h2);
        check_eq("rderr_err",  32'(t_err), 1);
        check_eq("rderr_nowr", t_wr_d, 0);
        check_eq("rderr_stb",  t_stb_d, 1);
        check_eq("rderr_lat",  t_lat, 2);
        slv_err_en = 1'b0;

        // Reset while in CALC
        slv_rdata = 32'h0000_0010;
        s_wr = mon_wr_cnt;
        @(negedge clk);
        req_i = 1'b1; req_op_i = 5'b00000; req_addr_i = 32'h40; req_data_i = 32'h1;
        @(negedge clk);
        req_i = 1'b0;
        @(negedge clk);
        check_eq("calc_cyc_pre", 32'(bus.cyc_o), 1);
        rst_n = 1'b0;
        #1;
        check_eq("arst_stb",  32'(bus.stb_o), 0);
        check_eq("arst_cyc",  32'(bus.cyc_o), 0);
        check_eq("arst_busy", 32'(busy_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("arst_nowr", mon_wr_cnt - s_wr, 0);
        slv_rdata = 32'hA5A5_5A5A;
        run_op(5'b00010, 32'h10, 32'h0);
        check_eq("post_lr_result", t_res, 32'hA5A5_5A5A);
        check_eq("post_lr_err",    32'(t_err), 0);
        check_eq("post_lr_lat",    t_lat, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
